// File: rtl/seg_pkg.sv
// Shared constants, converter state encoding and the 7-segment glyph table
// for the multiplexed score display.
package seg_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_BLANK  = 2'b10;
  localparam logic [1:0] MODE_LAMP   = 2'b11;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segments, bit 0 = a .. bit 6 = g.
  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg_encode = 7'h40;
      4'd1:    seg_encode = 7'h79;
      4'd2:    seg_encode = 7'h24;
      4'd3:    seg_encode = 7'h30;
      4'd4:    seg_encode = 7'h19;
      4'd5:    seg_encode = 7'h12;
      4'd6:    seg_encode = 7'h02;
      4'd7:    seg_encode = 7'h78;
      4'd8:    seg_encode = 7'h00;
      4'd9:    seg_encode = 7'h10;
      default: seg_encode = SEG_OFF;
    endcase
  endfunction

  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with one-deep pending slot and
// saturation to all-9s when the score does not fit in NUM_DIGITS digits.
//
//   state      | meaning
//   CONV_IDLE  | waiting for a strobe or a pending score
//   CONV_SHIFT | one add-3/shift step per cycle, SCORE_W steps
//   CONV_DONE  | result and ovf presented with load, back to idle
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 11
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_valid,
  output logic                    busy,
  output logic                    ovf,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    load
);

  localparam int          BW      = NUM_DIGITS * 4;
  localparam int          CW      = $clog2(SCORE_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  conv_state_t        state, state_nxt;
  logic [SCORE_W-1:0] sreg;
  logic [CW-1:0]      cnt;
  logic               pend_v;
  logic [SCORE_W-1:0] pend_score;
  logic               ovf_next;
  logic               start;
  logic               sat;
  logic [SCORE_W-1:0] src;
  logic [BW-1:0]      adj;
  logic [BW-1:0]      bcd_shift;

  always_comb begin
    start     = (state == CONV_IDLE) && (score_valid || pend_v);
    src       = score_valid ? score : pend_score;
    sat       = 64'(src) > MAX_VAL;
    adj       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    bcd_shift = BW'({adj, sreg[SCORE_W-1]});
    state_nxt = state;
    case (state)
      CONV_IDLE:  if (start) state_nxt = sat ? CONV_DONE : CONV_SHIFT;
      CONV_SHIFT: if (cnt == CW'(SCORE_W - 1)) state_nxt = CONV_DONE;
      CONV_DONE:  state_nxt = CONV_IDLE;
      default:    state_nxt = CONV_IDLE;
    endcase
    load = (state == CONV_DONE);
    busy = (state != CONV_IDLE) || pend_v;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= CONV_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      pend_v     <= 1'b0;
      pend_score <= '0;
      ovf_next   <= 1'b0;
      ovf        <= 1'b0;
      bcd        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CONV_IDLE: begin
          if (start) begin
            sreg     <= src;
            cnt      <= '0;
            ovf_next <= sat;
            bcd      <= sat ? {NUM_DIGITS{4'h9}} : '0;
            pend_v   <= 1'b0;
          end
        end
        CONV_SHIFT: begin
          bcd  <= bcd_shift;
          sreg <= sreg << 1;
          cnt  <= cnt + CW'(1);
        end
        CONV_DONE: ovf <= ovf_next;
        default: ;
      endcase
      // Strobes arriving mid-conversion overwrite the single pending slot.
      if (state != CONV_IDLE && score_valid) begin
        pend_v     <= 1'b1;
        pend_score <= score;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment driver: holds the displayed BCD value and
// scans anodes from clk with internal refresh and blink timing.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_W     = 11,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  score_valid,
  input  logic [1:0]            mode,
  input  logic                  lzb_en,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam int BW    = NUM_DIGITS * 4;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0]         conv_bcd;
  logic                  conv_load;
  logic [BW-1:0]         disp;
  logic [RW-1:0]         rcnt;
  logic [IDX_W-1:0]      idx;
  logic [BCW-1:0]        bcnt;
  logic                  phase;
  logic [NUM_DIGITS-1:0] blank_lz;
  logic [NUM_DIGITS-1:0] an_scan;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic [3:0]            nib;
  logic                  dig_blank;
  logic                  all_zero;

  assign dp = 1'b1;

  bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCORE_W   (SCORE_W)
  ) u_conv (
    .clk        (clk),
    .clr        (clr),
    .score      (score),
    .score_valid(score_valid),
    .busy       (busy),
    .ovf        (ovf),
    .bcd        (conv_bcd),
    .load       (conv_load)
  );

  always_comb begin
    all_zero  = 1'b1;
    blank_lz  = '0;
    // Walk from the most significant digit down; digit 0 always stays lit.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero && (disp[i*4 +: 4] == 4'h0);
      blank_lz[i] = lzb_en && (i != 0) && all_zero;
    end
    nib       = 4'h0;
    dig_blank = 1'b0;
    an_scan   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib        = disp[i*4 +: 4];
        dig_blank  = blank_lz[i];
        an_scan[i] = 1'b0;
      end
    end
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    case (mode)
      MODE_BLANK: begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
      end
      MODE_LAMP: begin
        an_nxt  = an_scan;
        seg_nxt = 7'h00;
      end
      default: begin
        if (!(mode == MODE_BLINK && phase) && !dig_blank) begin
          an_nxt  = an_scan;
          seg_nxt = seg_encode(nib);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      disp  <= '0;
      rcnt  <= '0;
      idx   <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
      seg   <= SEG_OFF;
      an    <= '1;
    end else begin
      if (conv_load) disp <= conv_bcd;
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      if (bcnt == BCW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BCW'(1);
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a 4-digit and a 2-digit instance share
// the stimulus; expected glyphs and scan slots come from a small model.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        clr;
  logic [10:0] score;
  logic        score_valid;
  logic [1:0]  mode;
  logic        lzb_en;
  logic        busy, ovf, dp;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy2, ovf2, dp2;
  logic [6:0]  seg2;
  logic [1:0]  an2;

  int n_assert = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCORE_W(11), .REFRESH_DIV(4), .BLINK_DIV(8)
  ) dut (
    .clk(clk), .clr(clr), .score(score), .score_valid(score_valid),
    .mode(mode), .lzb_en(lzb_en), .busy(busy), .ovf(ovf),
    .seg(seg), .an(an), .dp(dp)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS(2), .SCORE_W(11), .REFRESH_DIV(4), .BLINK_DIV(8)
  ) dut2 (
    .clk(clk), .clr(clr), .score(score), .score_valid(score_valid),
    .mode(mode), .lzb_en(lzb_en), .busy(busy2), .ovf(ovf2),
    .seg(seg2), .an(an2), .dp(dp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'h40;  1: enc = 7'h79;  2: enc = 7'h24;  3: enc = 7'h30;
      4: enc = 7'h19;  5: enc = 7'h12;  6: enc = 7'h02;  7: enc = 7'h78;
      8: enc = 7'h00;  9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  function automatic int digit_of(input int v, input int d);
    int x;
    x = v;
    for (int k = 0; k < d; k++) x = x / 10;
    return x % 10;
  endfunction

  task automatic strobe(input int v);
    score       = 11'(v);
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One full scan period: every lit digit must show its glyph for exactly
  // REFRESH_DIV samples, blanked digits keep all anodes high.
  task automatic check_scan(input bit sel, input int val, input bit lzb);
    int         nd, nblank, d, prevd, p, exp_blank;
    int         cnt[4];
    logic [3:0] a, one;
    logic [6:0] s;
    nd     = sel ? 2 : 4;
    nblank = 0;
    prevd  = -1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (4 * nd) begin
      tick();
      if (sel) begin a = {2'b11, an2}; s = seg2; end
      else     begin a = an;           s = seg;  end
      d = -1;
      for (int i = 0; i < nd; i++) begin
        one = 4'b0001 << i;
        if (a == ~one) d = i;
      end
      if (a == 4'hF) begin
        nblank++;
        prevd = -1;
        chk("blank_seg", {25'd0, s}, 32'h7F);
      end else if (d < 0) begin
        chk("an_onehot", {28'd0, a}, 32'hF);
      end else begin
        cnt[d]++;
        chk("digit_seg", {25'd0, s}, {25'd0, enc(digit_of(val, d))});
        if (prevd >= 0 && d != prevd) chk("scan_order", d, (prevd + 1) % nd);
        prevd = d;
      end
    end
    p         = 1;
    exp_blank = 0;
    for (int i = 0; i < nd; i++) begin
      if (!lzb || i == 0 || val >= p) chk("slot_count", cnt[i], 4);
      else begin
        chk("slot_count", cnt[i], 0);
        exp_blank += 4;
      end
      p = p * 10;
    end
    chk("blank_count", nblank, exp_blank);
  endtask

  initial begin
    int n, nf;
    bit seen42;
    int lc[4];
    clr         = 1'b0;
    score       = '0;
    score_valid = 1'b0;
    mode        = 2'b00;
    lzb_en      = 1'b1;
    repeat (3) tick();

    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_an2", {30'd0, an2}, 32'h3);

    clr = 1'b1;
    tick();
    check_scan(0, 0, 1);

    // 1234: busy for exactly 12 samples, then a full scan of 4,3,2,1
    strobe(1234);
    for (int i = 0; i < 12; i++) begin
      chk("busy_1234", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("busy_1234_end", {31'd0, busy}, 32'd0);
    check_scan(0, 1234, 1);

    strobe(7);
    wait_idle();
    check_scan(0, 7, 1);
    lzb_en = 1'b0;
    check_scan(0, 7, 0);

    // Overflow on the 2-digit instance: saturates to 99 two cycles out
    strobe(150);
    chk("ovf2_pre", {31'd0, ovf2}, 32'd0);
    chk("busy2_ovf", {31'd0, busy2}, 32'd1);
    tick();
    chk("ovf2_set", {31'd0, ovf2}, 32'd1);
    chk("busy2_ovf_end", {31'd0, busy2}, 32'd0);
    wait_idle();
    check_scan(1, 99, 0);

    strobe(42);
    repeat (11) tick();
    chk("ovf2_held", {31'd0, ovf2}, 32'd1);
    tick();
    chk("ovf2_clr", {31'd0, ovf2}, 32'd0);
    chk("busy2_42_end", {31'd0, busy2}, 32'd0);
    check_scan(1, 42, 0);
    check_scan(0, 42, 0);

    // Back-to-back: 5, then 42 and 99 while busy; 99 replaces 42
    tick();
    strobe(5);
    chk("b2b_busy0", {31'd0, busy}, 32'd1);
    tick();
    chk("b2b_busy1", {31'd0, busy}, 32'd1);
    strobe(42);
    chk("b2b_busy2", {31'd0, busy}, 32'd1);
    strobe(99);
    n      = 3;
    seen42 = 1'b0;
    while (busy && n < 60) begin
      if (an == 4'hD && seg == 7'h19) seen42 = 1'b1;
      n++;
      tick();
    end
    chk("b2b_busy_len", n, 25);
    chk("b2b_no_42", {31'd0, seen42}, 32'd0);
    chk("b2b_ovf2", {31'd0, ovf2}, 32'd0);
    check_scan(0, 99, 0);
    check_scan(1, 99, 0);

    // Modes
    mode = 2'b01;
    nf   = 0;
    repeat (32) begin
      tick();
      if (an == 4'hF) nf++;
    end
    chk("blink_dark_count", nf, 16);

    mode = 2'b10;
    repeat (2) begin
      tick();
      chk("blank_an", {28'd0, an}, 32'hF);
      chk("blank_seg_mode", {25'd0, seg}, 32'h7F);
      chk("blank_an2", {30'd0, an2}, 32'h3);
    end

    mode = 2'b11;
    for (int i = 0; i < 4; i++) lc[i] = 0;
    repeat (16) begin
      tick();
      chk("lamp_seg", {25'd0, seg}, 32'h00);
      case (an)
        4'hE: lc[0]++;
        4'hD: lc[1]++;
        4'hB: lc[2]++;
        4'h7: lc[3]++;
        default: chk("lamp_an", {28'd0, an}, 32'hE);
      endcase
    end
    for (int i = 0; i < 4; i++) chk("lamp_slots", lc[i], 4);

    // Reset mid-conversion: display returns to 0, no partial value shown
    mode   = 2'b00;
    lzb_en = 1'b1;
    strobe(150);
    tick();
    tick();
    chk("pre_rst_ovf2", {31'd0, ovf2}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    clr = 1'b0;
    #1;
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_an", {28'd0, an}, 32'hF);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ovf2", {31'd0, ovf2}, 32'd0);
    chk("mid_rst_an2", {30'd0, an2}, 32'h3);
    tick();
    clr = 1'b1;
    repeat (15) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    check_scan(0, 0, 1);
    check_scan(1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised successor to the score display path on the 7-segment display.
- Runs from a single system clock and derives its refresh and blink timing internally, so it needs no divided clocks.
- Converts a binary score to BCD sequentially and drives an N-digit multiplexed display.
- Supports leading-zero blanking, blink/blank/lamp-test modes and overflow saturation.

Parameters:
- NUM_DIGITS, 4: number of digits and anodes (1..8).
- SCORE_W, 11: width of the binary score input.
- REFRESH_DIV, 100000: clk cycles per digit scan slot.
- BLINK_DIV, 50000000: clk cycles per blink half-period.

Ports:
- clk  in  1  system clock, 100 MHz.
- clr  in  1  asynchronous reset, active-low.
- score  in  SCORE_W  binary value to display.
- score_valid  in  1  one-cycle load strobe for score.
- mode  in  2  display mode: 00 normal, 01 blink, 10 blank, 11 lamp test.
- lzb_en  in  1  leading-zero blanking enable.
- busy  out  1  conversion in progress or pending.
- ovf  out  1  last loaded score exceeded 10^NUM_DIGITS-1.
- seg  out  7  segments, active-low; seg[0]=a .. seg[6]=g.
- an  out  NUM_DIGITS  anodes, active-low, one-hot when lit; an[0] is the ones digit.
- dp  out  1  decimal point, active-low, tied off at 1.

Behaviour:
- Reset values (clr=0, asynchronous): seg=7'h7F, an=all 1, dp=1, busy=0, ovf=0, BCD display register=0, digit index=0, refresh counter=0, blink counter=0, blink phase=0, converter state=IDLE, pending flag=0.
- Converter FSM has three states: IDLE, SHIFT, DONE.
  - IDLE + score_valid: latch score.
  - If score > 10^NUM_DIGITS-1, go to DONE with the result forced to all-9s and ovf_next=1.
  - Otherwise go to SHIFT with ovf_next=0.
  - SHIFT: double-dabble, one bit per cycle, SCORE_W cycles (add-3 to any nibble >=5 before each shift).
  - DONE: load the display register and ovf atomically, then return to IDLE.
  - Latency, strobe to display register update: SCORE_W+2 cycles normally; 2 cycles on overflow.
- busy=1 from the cycle after an accepted strobe until the cycle after DONE, including while a load is pending.
- score_valid while not IDLE: score goes to a pending register and the pending flag is set (last write wins). After DONE the FSM starts the pending conversion immediately from IDLE, and busy stays 1 continuously.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At the terminal count the digit index increments, wrapping NUM_DIGITS-1 to 0.
  - seg/an are registered: they change one cycle after the index changes.
  - an[idx]=0 when the digit is lit; all other anodes are 1.
- Blink: the blink counter counts 0..BLINK_DIV-1 and toggles the phase at its terminal count; it runs freely in all modes.
- Output gating, by priority:
  - mode 10: an all 1, seg=7'h7F.
  - mode 11: seg=7'h00, anodes scan normally.
  - mode 01 with phase=1: an all 1.
  - Otherwise, normal display of the current digit.
- Leading-zero blanking: with lzb_en=1, digit i>0 is blanked (its anode kept at 1) when digits i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked, so a score of 0 shows a single "0".
- Digit encoding, active-low, a=bit0:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - Non-BCD nibble: 7'h7F.
- A mode change takes effect on the next registered output update. It does not reset the scan or blink counters.
- Reset mid-conversion: the conversion is abandoned and the display returns to 0. No partial BCD ever reaches the display register.

Decomposition:
- Package seg_pkg holds:
  - mode constants MODE_NORMAL/BLINK/BLANK/LAMP;
  - the converter state enum;
  - constant SEG_OFF=7'h7F;
  - function seg_encode(nibble) returning the active-low pattern.
- One sub-module, bin2bcd_seq. It owns the converter FSM, pending register, saturation and busy/ovf, and hands a NUM_DIGITS*4 BCD vector plus a load pulse to the scan logic in seg_scan_ctrl.

Test Plan:
- Reset: assert clr=0 mid-run → seg=7'h7F, an=4'hF, busy=0, ovf=0 on the same cycle; after release with mode=00 and score never loaded, only an=4'hE with seg=7'h40 when lzb_en=1.
- Load: REFRESH_DIV=4, score=1234 strobe → busy=1 for 12 cycles, then the scan shows an=E/seg=19, an=D/seg=30, an=B/seg=24, an=7/seg=79, each for 4 cycles, repeating.
- Leading-zero blanking: lzb_en=1, score=7 → an only ever E or F; seg=7'h78 when an=E. With lzb_en=0, all four anodes cycle, showing 0,0,0,7.
- Overflow: NUM_DIGITS=2, score=150 → ovf=1 and display "99" two cycles after the strobe; a following score=42 clears ovf and shows "42".
- Back-to-back: strobe 5, then strobe 42 two cycles later, then strobe 99 one cycle after that → busy stays high throughout, the display ends at 99 and never shows 42, and 5 appears only transiently.
- Modes: BLINK_DIV=8, mode=01 → an all 1 for 8 cycles alternating with normal scan; mode=10 → an=F, seg=7F; mode=11 → seg=7'h00 with anodes scanning.
